// File: rtl/hazard_unit_if.sv
// Bundle between the ID-stage decode/branch logic and the hazard unit.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_unit_if #(
    parameter int CNT_WIDTH = 16
);
    // There is no valid/ready pair. The inputs are sampled every cycle.
    // stall_o and stall_cause_o are valid in the same cycle as those inputs.
    // stall_cnt_o and state reflect the registered values.
    logic [4:0]           rs1_id_i;
    logic [4:0]           rs2_id_i;
    logic                 rs1_in_use_i;
    logic                 rs2_in_use_i;
    logic [1:0]           branch_id_i;
    logic [4:0]           rd_ex_i;
    logic                 rd_we_ex_i;
    logic                 mem_to_reg_ex_i;
    logic [4:0]           rd_mem_i;
    logic                 mem_to_reg_mem_i;
    logic                 stall_o;
    logic                 pc_en_o;
    logic                 if_id_en_o;
    logic                 id_ex_bubble_o;
    logic [1:0]           stall_cause_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [1:0]           state;

    modport master (
        output rs1_id_i, rs2_id_i, rs1_in_use_i, rs2_in_use_i, branch_id_i,
        output rd_ex_i, rd_we_ex_i, mem_to_reg_ex_i, rd_mem_i, mem_to_reg_mem_i,
        input  stall_o, pc_en_o, if_id_en_o, id_ex_bubble_o, stall_cause_o,
        input  stall_cnt_o, state
    );

    modport slave (
        input  rs1_id_i, rs2_id_i, rs1_in_use_i, rs2_in_use_i, branch_id_i,
        input  rd_ex_i, rd_we_ex_i, mem_to_reg_ex_i, rd_mem_i, mem_to_reg_mem_i,
        output stall_o, pc_en_o, if_id_en_o, id_ex_bubble_o, stall_cause_o,
        output stall_cnt_o, state
    );
endinterface

// File: rtl/hazard_unit.sv
// Detects RAW hazards between the ID stage and the EX/MEM stages.
// Generates the stall that freezes PC and IF/ID and bubbles ID/EX.
module hazard_unit #(
    parameter int CNT_WIDTH = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LB_HOLD = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LU   = 2'b01;
    localparam logic [1:0] CAUSE_BA   = 2'b10;
    localparam logic [1:0] CAUSE_LB   = 2'b11;

    state_t               state_q;
    state_t               state_d;
    logic                 stall;
    logic [1:0]           cause;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic ex_match;
    logic mem_match;
    logic valid_branch;
    logic h_lb;
    logic h_ba;
    logic h_bm;
    logic h_lu;

    // x0 is hardwired to zero, so it never carries a dependency.
    assign ex_match =
        (bus.rs1_in_use_i && (bus.rs1_id_i != 5'd0) && (bus.rs1_id_i == bus.rd_ex_i)) ||
        (bus.rs2_in_use_i && (bus.rs2_id_i != 5'd0) && (bus.rs2_id_i == bus.rd_ex_i));
    assign mem_match =
        (bus.rs1_in_use_i && (bus.rs1_id_i != 5'd0) && (bus.rs1_id_i == bus.rd_mem_i)) ||
        (bus.rs2_in_use_i && (bus.rs2_id_i != 5'd0) && (bus.rs2_id_i == bus.rd_mem_i));

    assign valid_branch = (bus.branch_id_i == 2'b01) || (bus.branch_id_i == 2'b10);

    assign h_lb = valid_branch && bus.mem_to_reg_ex_i && ex_match;
    assign h_ba = valid_branch && bus.rd_we_ex_i && !bus.mem_to_reg_ex_i && ex_match;
    assign h_bm = valid_branch && bus.mem_to_reg_mem_i && mem_match;
    assign h_lu = !valid_branch && bus.mem_to_reg_ex_i && ex_match;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall and cause depend on the inputs in IDLE and only on the state elsewhere.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        cause   = CAUSE_NONE;
        case (state_q)
            IDLE: begin
                if (h_lb) begin
                    stall   = 1'b1;
                    cause   = CAUSE_LB;
                    state_d = LB_HOLD;
                end else if (h_ba) begin
                    stall   = 1'b1;
                    cause   = CAUSE_BA;
                    state_d = RELEASE;
                end else if (h_bm) begin
                    stall   = 1'b1;
                    cause   = CAUSE_LB;
                    state_d = RELEASE;
                end else if (h_lu) begin
                    stall   = 1'b1;
                    cause   = CAUSE_LU;
                    state_d = RELEASE;
                end
            end
            LB_HOLD: begin
                stall   = 1'b1;
                cause   = CAUSE_LB;
                state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset) begin
            stall = 1'b0;
            cause = CAUSE_NONE;
        end
    end

    // Saturates at all-ones instead of wrapping, so long runs never read as few stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.pc_en_o        = !stall;
    assign bus.if_id_en_o     = !stall;
    assign bus.id_ex_bubble_o = stall;
    assign bus.stall_cause_o  = cause;
    assign bus.stall_cnt_o    = cnt_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with CNT_WIDTH=4.
// A scoreboard queue holds the expected outputs for each driven cycle.
module tb_hazard_unit;

    localparam int CW = 4;
    localparam int EW = 2 + 4 + 2 + CW;

    logic clk;
    logic reset;

    hazard_unit_if #(.CNT_WIDTH(CW)) bus ();

    hazard_unit #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            compared;
    int            mismatched;

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the hand-computed response.
    // The expected word is {state, stall, pc_en, if_id_en, bubble, cause, cnt}.
    task automatic vec(
        input string      nm,
        input logic       rst,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic       u1,  input logic u2,
        input logic [1:0] br,
        input logic [4:0] rdex, input logic we, input logic ldex,
        input logic [4:0] rdmem, input logic ldmem,
        input logic [1:0] e_state, input logic e_stall,
        input logic [1:0] e_cause, input int e_cnt
    );
        logic [CW-1:0] c;
        @(posedge clk);
        #1;
        reset                = rst;
        bus.rs1_id_i         = rs1;
        bus.rs2_id_i         = rs2;
        bus.rs1_in_use_i     = u1;
        bus.rs2_in_use_i     = u2;
        bus.branch_id_i      = br;
        bus.rd_ex_i          = rdex;
        bus.rd_we_ex_i       = we;
        bus.mem_to_reg_ex_i  = ldex;
        bus.rd_mem_i         = rdmem;
        bus.mem_to_reg_mem_i = ldmem;
        c = CW'(e_cnt);
        exp_q.push_back({e_state, e_stall, !e_stall, !e_stall, e_stall, e_cause, c});
        name_q.push_back(nm);
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] a;
            string         n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {bus.state, bus.stall_o, bus.pc_en_o, bus.if_id_en_o, bus.id_ex_bubble_o,
                 bus.stall_cause_o, bus.stall_cnt_o};
            compared = compared + 1;
            if (a !== e) begin
                mismatched = mismatched + 1;
                $display("FAIL %s: got {st,stall,pc,ifid,bub,cause,cnt}=%b required %b", n, a, e);
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        bus.rs1_id_i = '0; bus.rs2_id_i = '0; bus.rs1_in_use_i = 1'b0; bus.rs2_in_use_i = 1'b0;
        bus.branch_id_i = '0; bus.rd_ex_i = '0; bus.rd_we_ex_i = 1'b0; bus.mem_to_reg_ex_i = 1'b0;
        bus.rd_mem_i = '0; bus.mem_to_reg_mem_i = 1'b0;

        //   name           rst rs1 rs2 u1 u2 br     rdex we ld rdmem ldm  st     stl cause  cnt
        vec("rst_forced",   0,  5,  0,  1, 0, 2'b00, 5,   0, 1, 0,    0,   2'd0, 0, 2'b00, 0);
        vec("rst_idle",     0,  0,  0,  0, 0, 2'b00, 0,   0, 0, 0,    0,   2'd0, 0, 2'b00, 0);
        vec("idle",         1,  0,  0,  0, 0, 2'b00, 0,   0, 0, 0,    0,   2'd0, 0, 2'b00, 0);
        vec("lu_stall",     1,  5,  7,  1, 1, 2'b00, 5,   1, 1, 0,    0,   2'd0, 1, 2'b01, 0);
        vec("lu_release",   1,  5,  7,  1, 1, 2'b00, 5,   1, 1, 0,    0,   2'd2, 0, 2'b00, 1);
        vec("lu_idle",      1,  0,  0,  0, 0, 2'b00, 0,   0, 0, 0,    0,   2'd0, 0, 2'b00, 1);
        vec("lb_stall1",    1,  3,  3,  1, 1, 2'b01, 3,   1, 1, 0,    0,   2'd0, 1, 2'b11, 1);
        vec("lb_stall2",    1,  3,  3,  1, 1, 2'b01, 3,   1, 1, 0,    0,   2'd1, 1, 2'b11, 2);
        vec("lb_release",   1,  3,  3,  1, 1, 2'b01, 3,   1, 1, 0,    0,   2'd2, 0, 2'b00, 3);
        vec("lb_idle",      1,  0,  0,  0, 0, 2'b00, 0,   0, 0, 0,    0,   2'd0, 0, 2'b00, 3);
        vec("ba_stall",     1,  4,  0,  1, 1, 2'b01, 4,   1, 0, 0,    0,   2'd0, 1, 2'b10, 3);
        vec("ba_release",   1,  4,  0,  1, 1, 2'b01, 4,   1, 0, 0,    0,   2'd2, 0, 2'b00, 4);
        vec("ba_x0",        1,  0,  0,  1, 1, 2'b01, 0,   1, 0, 0,    0,   2'd0, 0, 2'b00, 4);
        vec("bm_stall",     1,  9,  0,  1, 0, 2'b10, 0,   0, 0, 9,    1,   2'd0, 1, 2'b11, 4);
        vec("bm_release",   1,  9,  0,  1, 0, 2'b10, 0,   0, 0, 9,    1,   2'd2, 0, 2'b00, 5);
        vec("bm_unused",    1,  9,  0,  0, 0, 2'b10, 0,   0, 0, 9,    1,   2'd0, 0, 2'b00, 5);
        vec("br11_lu",      1,  0,  7,  0, 1, 2'b11, 7,   1, 1, 0,    0,   2'd0, 1, 2'b01, 5);
        vec("br11_release", 1,  0,  7,  0, 1, 2'b11, 7,   1, 1, 0,    0,   2'd2, 0, 2'b00, 6);
        vec("prio_ba_bm",   1,  8,  6,  1, 1, 2'b01, 8,   1, 0, 6,    1,   2'd0, 1, 2'b10, 6);
        vec("prio_release", 1,  8,  6,  1, 1, 2'b01, 8,   1, 0, 6,    1,   2'd2, 0, 2'b00, 7);
        vec("rst_lb_trig",  1,  3,  0,  1, 0, 2'b01, 3,   1, 1, 0,    0,   2'd0, 1, 2'b11, 7);
        vec("rst_in_hold",  0,  3,  0,  1, 0, 2'b01, 3,   1, 1, 0,    0,   2'd1, 0, 2'b00, 8);
        vec("rst_after",    1,  0,  0,  0, 0, 2'b00, 0,   0, 0, 0,    0,   2'd0, 0, 2'b00, 0);
        vec("rs2_unused",   1,  0,  5,  0, 0, 2'b00, 5,   1, 1, 0,    0,   2'd0, 0, 2'b00, 0);

        // Saturation: twenty load-use hazards on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            vec("sat_stall",   1, 5, 0, 1, 0, 2'b00, 5, 1, 1, 0, 0, 2'd0, 1, 2'b01,
                (i < 15) ? i : 15);
            vec("sat_release", 1, 5, 0, 1, 0, 2'b00, 5, 1, 1, 0, 0, 2'd2, 0, 2'b00,
                (i + 1 < 15) ? i + 1 : 15);
        end
        vec("sat_hold",     1,  0,  0,  0, 0, 2'b00, 0,   0, 0, 0,    0,   2'd0, 0, 2'b00, 15);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
